// File: rtl/accelbrot_pkg.sv
// Shared types and helpers for the accelbrot scan front end.
package accelbrot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_SEND  = 2'd2,
    ST_DRAIN = 2'd3
  } scan_state_e;

  localparam int unsigned TAG_MAX_W = 64;

  // Pixel tag is {y, x}; callers truncate to their tag width.
  function automatic logic [TAG_MAX_W-1:0] pack_tag(input logic [31:0] y,
                                                    input logic [31:0] x,
                                                    input int unsigned dwidth);
    pack_tag = (TAG_MAX_W'(y) << dwidth) | TAG_MAX_W'(x);
  endfunction

endpackage

// File: rtl/accelbrot_scan_ctrl_if.sv
// Enter-side word stream into the iteration loop plus the retire strobe coming back.
interface accelbrot_scan_ctrl_if #(
  parameter int unsigned WWIDTH = 34,
  parameter int unsigned TWIDTH = 24
);
  logic [WWIDTH-1:0] enter_a;
  logic [WWIDTH-1:0] enter_b;
  logic [TWIDTH-1:0] enter_tag;
  logic              enter_start;
  logic              enter_valid;
  logic              enter_bp;
  logic              exit_fire;

  modport master (
    output enter_a, enter_b, enter_tag, enter_start, enter_valid,
    input  enter_bp, exit_fire
  );

  modport slave (
    input  enter_a, enter_b, enter_tag, enter_start, enter_valid,
    output enter_bp, exit_fire
  );
endinterface

// File: rtl/accelbrot_scan_acc.sv
// Per-pixel coordinate accumulators (a = a0 + x*da, b = b0 + y*db) and operand word select.
module accelbrot_scan_acc
  import accelbrot_pkg::*;
#(
  parameter int unsigned NWORDS = 8,
  parameter int unsigned WWIDTH = 34,
  parameter int unsigned KWIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_load,
  input  logic                     i_step_x,
  input  logic                     i_wrap_row,
  input  logic [NWORDS*WWIDTH-1:0] i_a0,
  input  logic [NWORDS*WWIDTH-1:0] i_b0,
  input  logic [NWORDS*WWIDTH-1:0] i_da,
  input  logic [NWORDS*WWIDTH-1:0] i_db,
  input  logic [KWIDTH-1:0]        i_word_sel,
  output logic [WWIDTH-1:0]        o_word_a_c,
  output logic [WWIDTH-1:0]        o_word_b_c
);
  localparam int unsigned BWIDTH = NWORDS * WWIDTH;

  logic [BWIDTH-1:0] r_a0;
  logic [BWIDTH-1:0] r_da;
  logic [BWIDTH-1:0] r_db;
  logic [BWIDTH-1:0] r_a_cur;
  logic [BWIDTH-1:0] r_b_cur;
  logic [31:0]       w_shift;

  // Modulo-2^BWIDTH stepping; a restarts from a0 at each row wrap.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_a0    <= '0;
      r_da    <= '0;
      r_db    <= '0;
      r_a_cur <= '0;
      r_b_cur <= '0;
    end else if (i_load) begin
      r_a0    <= i_a0;
      r_da    <= i_da;
      r_db    <= i_db;
      r_a_cur <= i_a0;
      r_b_cur <= i_b0;
    end else if (i_wrap_row) begin
      r_a_cur <= r_a0;
      r_b_cur <= r_b_cur + r_db;
    end else if (i_step_x) begin
      r_a_cur <= r_a_cur + r_da;
    end
  end

  assign w_shift    = 32'(i_word_sel) * WWIDTH;
  assign o_word_a_c = WWIDTH'(r_a_cur >> w_shift);
  assign o_word_b_c = WWIDTH'(r_b_cur >> w_shift);

endmodule

// File: rtl/accelbrot_scan_ctrl.sv
// Raster scan controller: walks a frame, issues each pixel as NWORDS operand words under a credit limit.
module accelbrot_scan_ctrl
  import accelbrot_pkg::*;
#(
  parameter int unsigned NWORDS = 8,
  parameter int unsigned WWIDTH = 34,
  parameter int unsigned DWIDTH = 12,
  parameter int unsigned TWIDTH = 24,
  parameter int unsigned FWIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     cmd_start,
  input  logic                     cmd_abort,
  input  logic [DWIDTH-1:0]        cfg_width,
  input  logic [DWIDTH-1:0]        cfg_height,
  input  logic [NWORDS*WWIDTH-1:0] cfg_a0,
  input  logic [NWORDS*WWIDTH-1:0] cfg_b0,
  input  logic [NWORDS*WWIDTH-1:0] cfg_da,
  input  logic [NWORDS*WWIDTH-1:0] cfg_db,
  input  logic [FWIDTH-1:0]        cfg_max_inflight,
  accelbrot_scan_ctrl_if.master    enter_if,
  output logic                     sts_busy,
  output logic                     sts_done,
  output logic [2*DWIDTH-1:0]      sts_issued,
  output logic [FWIDTH-1:0]        sts_inflight,
  output logic                     sts_err
);
  localparam int unsigned KWIDTH = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int unsigned IWIDTH = 2 * DWIDTH;
  localparam logic [KWIDTH-1:0] LAST_WORD = KWIDTH'(NWORDS - 1);

  scan_state_e r_state, w_state_nx;

  logic [DWIDTH-1:0] r_width, r_height, r_x, r_y;
  logic [FWIDTH-1:0] r_max_eff, r_inflight;
  logic [IWIDTH-1:0] r_issued;
  logic [KWIDTH-1:0] r_word;
  logic              r_empty, r_all_issued, r_abort_pend;
  logic              r_busy, r_done, r_err;
  logic              r_enter_valid, r_enter_start;
  logic [WWIDTH-1:0] r_enter_a, r_enter_b;
  logic [TWIDTH-1:0] r_enter_tag;

  logic              w_load, w_stop, w_grant, w_last_word, w_row_end, w_frame_end;
  logic [KWIDTH-1:0] w_word_sel;
  logic [WWIDTH-1:0] w_word_a, w_word_b;

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE:  if (cmd_start) w_state_nx = ST_ARB;
      ST_ARB: begin
        if (w_stop)       w_state_nx = ST_DRAIN;
        else if (w_grant) w_state_nx = ST_SEND;
      end
      ST_SEND:  if (r_word == LAST_WORD) w_state_nx = ST_ARB;
      ST_DRAIN: if (r_inflight == '0) w_state_nx = ST_IDLE;
      default:  w_state_nx = ST_IDLE;
    endcase
  end

  // Control strobes; a pending abort or an exhausted frame blocks any further grant.
  always_comb begin
    w_load      = 1'b0;
    w_stop      = 1'b0;
    w_grant     = 1'b0;
    w_last_word = 1'b0;
    w_word_sel  = '0;
    w_row_end   = (r_x == r_width - DWIDTH'(1));
    w_frame_end = w_row_end && (r_y == r_height - DWIDTH'(1));
    case (r_state)
      ST_IDLE: w_load = cmd_start;
      ST_ARB: begin
        w_stop  = r_abort_pend | cmd_abort | r_all_issued | r_empty;
        w_grant = !w_stop && !enter_if.enter_bp && (r_inflight < r_max_eff);
      end
      ST_SEND: begin
        w_last_word = (r_word == LAST_WORD);
        w_word_sel  = r_word + KWIDTH'(1);
      end
      default: ;
    endcase
  end

  accelbrot_scan_acc #(
    .NWORDS (NWORDS),
    .WWIDTH (WWIDTH),
    .KWIDTH (KWIDTH)
  ) u_acc (
    .clk        (clk),
    .rstn       (rstn),
    .i_load     (w_load),
    .i_step_x   (w_last_word && !w_row_end),
    .i_wrap_row (w_last_word && w_row_end),
    .i_a0       (cfg_a0),
    .i_b0       (cfg_b0),
    .i_da       (cfg_da),
    .i_db       (cfg_db),
    .i_word_sel (w_word_sel),
    .o_word_a_c (w_word_a),
    .o_word_b_c (w_word_b)
  );

  // Frame configuration, scan position and status bookkeeping.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_width      <= '0;
      r_height     <= '0;
      r_max_eff    <= FWIDTH'(1);
      r_empty      <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_issued     <= '0;
      r_all_issued <= 1'b0;
      r_abort_pend <= 1'b0;
      r_inflight   <= '0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      if (w_load) begin
        r_width      <= cfg_width;
        r_height     <= cfg_height;
        r_max_eff    <= (cfg_max_inflight == '0) ? FWIDTH'(1) : cfg_max_inflight;
        r_empty      <= (cfg_width == '0) || (cfg_height == '0);
        r_x          <= '0;
        r_y          <= '0;
        r_issued     <= '0;
        r_all_issued <= 1'b0;
        r_abort_pend <= 1'b0;
      end else begin
        if (cmd_abort && r_state != ST_IDLE) r_abort_pend <= 1'b1;
        if (w_grant) begin
          r_issued <= r_issued + IWIDTH'(1);
          if (w_frame_end) r_all_issued <= 1'b1;
        end
        if (w_last_word) begin
          if (w_row_end) begin
            r_x <= '0;
            r_y <= r_y + DWIDTH'(1);
          end else begin
            r_x <= r_x + DWIDTH'(1);
          end
        end
      end
      // Retires are counted in every state so late exits after a frame still drain.
      if (w_grant && !enter_if.exit_fire) begin
        r_inflight <= r_inflight + FWIDTH'(1);
      end else if (!w_grant && enter_if.exit_fire) begin
        if (r_inflight == '0) r_err <= 1'b1;
        else                  r_inflight <= r_inflight - FWIDTH'(1);
      end
      r_busy <= (w_state_nx != ST_IDLE);
      r_done <= (r_state == ST_DRAIN) && (r_inflight == '0);
    end
  end

  // Word stream: grant loads word 0, each SEND cycle loads the next until the last word.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_word        <= '0;
      r_enter_valid <= 1'b0;
      r_enter_start <= 1'b0;
      r_enter_a     <= '0;
      r_enter_b     <= '0;
      r_enter_tag   <= '0;
    end else begin
      r_enter_start <= w_grant;
      if (w_grant) begin
        r_word      <= '0;
        r_enter_tag <= TWIDTH'(pack_tag(32'(r_y), 32'(r_x), DWIDTH));
      end else if (r_state == ST_SEND) begin
        r_word <= r_word + KWIDTH'(1);
      end
      if (w_grant || (r_state == ST_SEND && !w_last_word)) begin
        r_enter_valid <= 1'b1;
        r_enter_a     <= w_word_a;
        r_enter_b     <= w_word_b;
      end else begin
        r_enter_valid <= 1'b0;
      end
    end
  end

  assign enter_if.enter_a     = r_enter_a;
  assign enter_if.enter_b     = r_enter_b;
  assign enter_if.enter_tag   = r_enter_tag;
  assign enter_if.enter_start = r_enter_start;
  assign enter_if.enter_valid = r_enter_valid;
  assign sts_busy             = r_busy;
  assign sts_done             = r_done;
  assign sts_issued           = r_issued;
  assign sts_inflight         = r_inflight;
  assign sts_err              = r_err;

endmodule

// File: tb/tb_accelbrot_scan_ctrl.sv
// Scoreboard bench for accelbrot_scan_ctrl: expected pixels queued at frame start, checked word by word.
module tb_accelbrot_scan_ctrl;
  localparam int unsigned NW = 8;
  localparam int unsigned WW = 34;
  localparam int unsigned DW = 12;
  localparam int unsigned TW = 24;
  localparam int unsigned FW = 10;
  localparam int unsigned BW = NW * WW;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cmd_start = 1'b0;
  logic          cmd_abort = 1'b0;
  logic [DW-1:0] cfg_width = '0;
  logic [DW-1:0] cfg_height = '0;
  logic [BW-1:0] cfg_a0 = '0, cfg_b0 = '0, cfg_da = '0, cfg_db = '0;
  logic [FW-1:0] cfg_max_inflight = '0;
  logic          sts_busy, sts_done, sts_err;
  logic [2*DW-1:0] sts_issued;
  logic [FW-1:0] sts_inflight;

  always #5 clk = ~clk;

  accelbrot_scan_ctrl_if #(.WWIDTH(WW), .TWIDTH(TW)) bus ();

  accelbrot_scan_ctrl #(
    .NWORDS(NW), .WWIDTH(WW), .DWIDTH(DW), .TWIDTH(TW), .FWIDTH(FW)
  ) dut (
    .clk(clk), .rstn(rstn), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_a0(cfg_a0), .cfg_b0(cfg_b0), .cfg_da(cfg_da), .cfg_db(cfg_db),
    .cfg_max_inflight(cfg_max_inflight), .enter_if(bus),
    .sts_busy(sts_busy), .sts_done(sts_done), .sts_issued(sts_issued),
    .sts_inflight(sts_inflight), .sts_err(sts_err)
  );

  typedef struct {
    logic [TW-1:0] tag;
    logic [BW-1:0] a;
    logic [BW-1:0] b;
  } pix_t;

  pix_t exp_q[$];
  int   exit_q[$];
  pix_t cur;
  int   n_chk = 0, n_err = 0;
  int   cyc = 0, valid_cnt = 0, starts = 0, exits = 0, done_cnt = 0;
  int   word_k = 0, in_pix = 0, lat = -1, start_cyc = 0, awaiting = 0;
  int   prev_start = 0, have_prev = 0, min_per = 1000, peak = 0, one_viol = 0;
  int   force_req = 0, force_ack = 0, exit_dly = 10, lim1 = 0;
  int   done_base = 0, exit_base = 0;

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] rnd_b();
    logic [BW-1:0] r = '0;
    for (int i = 0; i < 9; i++) r = (r << 32) | BW'($urandom);
    return r;
  endfunction

  // Monitor: pops expected pixels, checks every word, and retires pixels after exit_dly cycles.
  initial begin
    bus.exit_fire = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstn) begin
        bus.exit_fire = 1'b0;
        in_pix = 0;
      end else begin
        if (bus.exit_fire) exits++;
        if (sts_done) done_cnt++;
        if (cmd_start && !sts_busy) begin
          start_cyc = cyc; awaiting = 1; have_prev = 0; min_per = 1000; peak = 0; one_viol = 0;
        end
        if (int'(sts_inflight) > peak) peak = int'(sts_inflight);
        if (bus.enter_valid) begin
          valid_cnt++;
          if (bus.enter_start) begin
            if (in_pix != 0) check_val("pix_words", 64'(word_k + 1), 64'(NW));
            if (lim1 != 0 && starts != exits) one_viol++;
            if (awaiting != 0) begin lat = cyc - start_cyc; awaiting = 0; end
            if (have_prev != 0 && cyc - prev_start < min_per) min_per = cyc - prev_start;
            prev_start = cyc; have_prev = 1; starts++;
            exit_q.push_back(cyc + exit_dly);
            if (exp_q.size() == 0) begin
              check_val("extra_pixel", 64'(1), 64'(0));
              cur = '{default: '0};
            end else begin
              cur = exp_q.pop_front();
            end
            word_k = 0; in_pix = 1;
          end else if (in_pix != 0) begin
            word_k++;
          end else begin
            check_val("orphan_word", 64'(1), 64'(0));
          end
          if (in_pix != 0) begin
            check_val("tag", 64'(bus.enter_tag), 64'(cur.tag));
            check_val("word_a", 64'(bus.enter_a), 64'(WW'(cur.a >> (word_k * WW))));
            check_val("word_b", 64'(bus.enter_b), 64'(WW'(cur.b >> (word_k * WW))));
            if (word_k == NW - 1) in_pix = 0;
          end
        end else if (in_pix != 0) begin
          check_val("pix_words", 64'(word_k + 1), 64'(NW));
          in_pix = 0;
        end
        bus.exit_fire = 1'b0;
        if (force_ack != force_req) begin
          force_ack++;
          bus.exit_fire = 1'b1;
        end else if (exit_q.size() > 0 && exit_q[0] <= cyc) begin
          void'(exit_q.pop_front());
          bus.exit_fire = 1'b1;
        end
      end
    end
  end

  task automatic setup_frame(input int w, input int h, input logic [BW-1:0] a0, input logic [BW-1:0] b0,
                             input logic [BW-1:0] da, input logic [BW-1:0] db,
                             input int mx, input int dly, input int limit);
    int n = 0;
    cfg_width = DW'(w); cfg_height = DW'(h);
    cfg_a0 = a0; cfg_b0 = b0; cfg_da = da; cfg_db = db;
    cfg_max_inflight = FW'(mx);
    exit_dly = dly;
    lim1 = (mx <= 1) ? 1 : 0;
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        if (n < limit) begin
          exp_q.push_back('{tag: TW'((y << DW) | x), a: a0 + BW'(x) * da, b: b0 + BW'(y) * db});
          n++;
        end
  endtask

  task automatic start_frame();
    done_base = done_cnt;
    exit_base = exits;
    @(posedge clk); #1;
    cmd_start = 1'b1;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    cfg_width = DW'(7); cfg_height = DW'(5); cfg_max_inflight = FW'(2);
    cfg_a0 = rnd_b(); cfg_b0 = rnd_b(); cfg_da = rnd_b(); cfg_db = rnd_b();
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == done_base; i++) begin
      @(negedge clk); #1;
    end
    check_val("done_seen", 64'(done_cnt > done_base), 64'(1));
  endtask

  task automatic finish_frame(input int exp_n);
    repeat (4) @(negedge clk);
    #1;
    check_val("done_pulses", 64'(done_cnt - done_base), 64'(1));
    check_val("issued", 64'(sts_issued), 64'(exp_n));
    check_val("exits", 64'(exits - exit_base), 64'(exp_n));
    check_val("busy_idle", 64'(sts_busy), 64'(0));
    check_val("inflight_idle", 64'(sts_inflight), 64'(0));
    check_val("sb_left", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int vbase, sbase, found;
    bus.enter_bp = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_valid", 64'(bus.enter_valid), 64'(0));
    check_val("rst_start", 64'(bus.enter_start), 64'(0));
    check_val("rst_busy", 64'(sts_busy), 64'(0));
    check_val("rst_done", 64'(sts_done), 64'(0));
    check_val("rst_err", 64'(sts_err), 64'(0));
    check_val("rst_issued", 64'(sts_issued), 64'(0));
    check_val("rst_inflight", 64'(sts_inflight), 64'(0));
    check_val("rst_a", 64'(bus.enter_a), 64'(0));
    check_val("rst_tag", 64'(bus.enter_tag), 64'(0));
    @(posedge clk); #1;
    rstn = 1'b1;

    // 2x2 frame: tags, latency, back-to-back pixel period
    setup_frame(2, 2, rnd_b(), rnd_b(), rnd_b(), rnd_b(), 4, 10, 4);
    start_frame();
    wait_done(300);
    check_val("first_latency", 64'(lat), 64'(2));
    check_val("pixel_period", 64'(min_per), 64'(NW + 1));
    finish_frame(4);

    // a0=0, da=1 then da=-1 on a 3x1 row
    setup_frame(3, 1, '0, rnd_b(), BW'(1), rnd_b(), 4, 5, 3);
    start_frame();
    wait_done(300);
    finish_frame(3);
    setup_frame(3, 1, '0, rnd_b(), '1, rnd_b(), 4, 5, 3);
    start_frame();
    wait_done(300);
    finish_frame(3);

    // credit limit of one (and zero treated as one)
    setup_frame(3, 1, rnd_b(), rnd_b(), rnd_b(), rnd_b(), 1, 50, 3);
    start_frame();
    wait_done(600);
    check_val("one_credit_overlap", 64'(one_viol), 64'(0));
    check_val("one_credit_peak", 64'(peak), 64'(1));
    finish_frame(3);
    setup_frame(2, 1, rnd_b(), rnd_b(), rnd_b(), rnd_b(), 0, 20, 2);
    start_frame();
    wait_done(300);
    check_val("zero_credit_peak", 64'(peak), 64'(1));
    finish_frame(2);

    // backpressure before grant, then raised mid-pixel
    setup_frame(2, 1, rnd_b(), rnd_b(), rnd_b(), rnd_b(), 4, 10, 2);
    bus.enter_bp = 1'b1;
    start_frame();
    vbase = valid_cnt;
    repeat (20) @(negedge clk);
    #1;
    check_val("bp_hold_valid", 64'(valid_cnt - vbase), 64'(0));
    check_val("bp_hold_busy", 64'(sts_busy), 64'(1));
    sbase = starts;
    bus.enter_bp = 1'b0;
    found = 0;
    for (int i = 0; i < 50 && found == 0; i++) begin
      @(negedge clk); #1;
      if (in_pix != 0 && word_k == 2) found = 1;
    end
    check_val("bp_mid_reached", 64'(found), 64'(1));
    bus.enter_bp = 1'b1;
    repeat (15) @(negedge clk);
    #1;
    check_val("bp_blocks_grant", 64'(starts - sbase), 64'(1));
    bus.enter_bp = 1'b0;
    wait_done(300);
    finish_frame(2);

    // abort while pixel 3 word 4 of a 4x4 frame is on the bus
    setup_frame(4, 4, rnd_b(), rnd_b(), rnd_b(), rnd_b(), 4, 10, 4);
    start_frame();
    sbase = starts - 0;
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(negedge clk); #1;
      if (starts - sbase == 4 && in_pix != 0 && word_k == 4) found = 1;
    end
    check_val("abort_point", 64'(found), 64'(1));
    cmd_abort = 1'b1;
    @(posedge clk); #1;
    cmd_abort = 1'b0;
    wait_done(300);
    finish_frame(4);

    // retire with nothing outstanding, then an empty frame
    check_val("err_before", 64'(sts_err), 64'(0));
    force_req++;
    repeat (3) @(negedge clk);
    #1;
    check_val("err_sticky", 64'(sts_err), 64'(1));
    check_val("err_inflight", 64'(sts_inflight), 64'(0));
    setup_frame(0, 3, rnd_b(), rnd_b(), rnd_b(), rnd_b(), 4, 10, 0);
    vbase = valid_cnt;
    start_frame();
    wait_done(50);
    check_val("empty_valid", 64'(valid_cnt - vbase), 64'(0));
    finish_frame(0);
    check_val("err_still", 64'(sts_err), 64'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/accelbrot_scan_ctrl.md
ACCELBROT_SCAN_CTRL -- requirements
Module: accelbrot_scan_ctrl

Interface
REQ-001 SHALL have parameter NWORDS, default 8, words per multiword operand.
REQ-002 SHALL have parameter WWIDTH, default 34, bits per word; BWIDTH = NWORDS*WWIDTH.
REQ-003 SHALL have parameter DWIDTH, default 12, bits per pixel coordinate.
REQ-004 SHALL have parameter TWIDTH, default 24, tag width; TWIDTH >= 2*DWIDTH.
REQ-005 SHALL have parameter FWIDTH, default 10, in-flight counter width.
REQ-006 Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- cmd_start  in  1  frame start pulse.
- cmd_abort  in  1  stop issuing and drain.
- cfg_width  in  DWIDTH  pixels per row.
- cfg_height  in  DWIDTH  rows.
- cfg_a0, cfg_b0  in  BWIDTH  origin (two's complement).
- cfg_da, cfg_db  in  BWIDTH  x-step and y-step.
- cfg_max_inflight  in  FWIDTH  credit limit.
- enter_a, enter_b  out  WWIDTH  operand word.
- enter_tag  out  TWIDTH  pixel tag.
- enter_start  out  1  first word of a pixel.
- enter_valid  out  1  word valid.
- enter_bp  in  1  loop backpressure.
- exit_fire  in  1  one pixel retired (exit_valid & exit_ready).
- sts_busy  out  1  frame in progress.
- sts_done  out  1  one-cycle completion pulse.
- sts_issued  out  2*DWIDTH  pixels issued this frame.
- sts_inflight  out  FWIDTH  pixels outstanding.
- sts_err  out  1  sticky credit-underflow flag.

Function
REQ-007 SHALL latch all cfg_* when cmd_start is sampled in IDLE; cfg changes mid-frame SHALL have no effect.
REQ-008 SHALL implement states IDLE, ARB, SEND, DRAIN. IDLE->ARB on cmd_start; ARB->SEND on grant; SEND->ARB after word NWORDS-1; ARB->DRAIN when all pixels issued or abort pending; DRAIN->IDLE when inflight==0, pulsing sts_done that cycle.
REQ-009 SHALL grant in ARB only when enter_bp==0 and inflight < max(cfg_max_inflight,1).
REQ-010 SHALL, after a grant, drive exactly NWORDS consecutive cycles of enter_valid=1, word k (LSW first, k=0..NWORDS-1) of a_cur/b_cur, enter_start=1 only for k=0; enter_bp SHALL be ignored inside SEND.
REQ-011 SHALL drive enter_tag = {y, x} zero-extended to TWIDTH, constant over the pixel's words.
REQ-012 SHALL scan x=0..cfg_width-1 within row, y=0..cfg_height-1; a_cur = a0 + x*da, b_cur = b0 + y*db, by full-width modulo-2^BWIDTH accumulation (no multiplier): a_cur += da per pixel, reset to a0 and b_cur += db at row wrap.
REQ-013 SHALL present first word 2 cycles after cmd_start is sampled when the grant is immediate; minimum pixel period NWORDS+1 cycles.
REQ-014 SHALL increment inflight on grant, decrement on exit_fire; simultaneous grant and exit_fire SHALL leave it unchanged.
REQ-015 SHALL, on exit_fire with inflight==0 (no same-cycle grant), hold inflight at 0 and set sts_err until reset.
REQ-016 SHALL, on cmd_abort, finish any SEND in progress, issue no further pixels, then DRAIN; abort in IDLE ignored.
REQ-017 SHALL ignore cmd_start while sts_busy=1; sts_busy=1 in ARB/SEND/DRAIN.
REQ-018 SHALL treat cfg_width==0 or cfg_height==0 as empty frame: ARB->DRAIN, zero pixels, sts_done after inflight==0.
REQ-019 SHALL count exit_fire in all states, so late exits after a completed frame are still consumed.

Reset
REQ-020 SHALL on rstn==0 at clk edge: state IDLE, enter_valid/enter_start/sts_busy/sts_done/sts_err=0, sts_issued=0, sts_inflight=0, enter_a/b/tag=0; reset mid-frame SHALL drop the frame with no sts_done.

Structure
REQ-021 SHALL take its state enum and tag-pack helper from shared package accelbrot_pkg.
REQ-022 SHALL place a_cur/b_cur accumulation and word select in sub-module accelbrot_scan_acc.

Verification
REQ-023 NWORDS=8, 2x2 frame, bp=0, max=4, exits after 10 cycles -> 4 pixels, tags 0x000000,0x000001,0x001000,0x001001, 8 words each, one sts_done.
REQ-024 a0=0, da=1, 3x1 frame -> word0 of enter_a = 0,1,2; upper words 0; da=-1 -> pixel 1 all words 0x3FFFFFFFF.
REQ-025 max_inflight=1, exit_fire 50 cycles after each grant -> no second enter_start before exit_fire; sts_inflight never exceeds 1.
REQ-026 enter_bp=1 at grant time, released after 20 cycles -> no enter_valid during bp; bp raised mid-SEND -> all 8 words still sent.
REQ-027 cmd_abort during pixel 3 word 4 of 4x4 -> pixel 3 completes, sts_issued=4, sts_done after 4 exits.
REQ-028 exit_fire in IDLE with inflight=0 -> sts_err=1, sts_inflight=0; cfg_width=0 -> sts_done, zero enter_valid.
